// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush controller for the 5-stage ARM pipeline.
//   It combines three sources:
//     - RAW hazards detected in ID.
//     - EXE branch-taken.
//     - A wait-state handshake FSM for the MEM-stage SRAM.
//   It also keeps a saturating count of freeze cycles.
//   Optional build macro: FORWARDING_EN. When it is defined, a forwarding unit
//   resolves most RAW cases, so only load-use against EXE still stalls.
module pipeline_hazard_ctrl #(
   parameter int REGFILE_ADDRESS_LEN = 4,
   parameter int SRAM_TIMEOUT        = 15,
   parameter int CNT_LEN             = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [REGFILE_ADDRESS_LEN-1:0] id_src1,
   input  logic [REGFILE_ADDRESS_LEN-1:0] id_src2,
   input  logic                           id_use_src1,
   input  logic                           id_use_src2,
   input  logic [REGFILE_ADDRESS_LEN-1:0] exe_dest,
   input  logic                           exe_wb_en,
   input  logic                           exe_mem_read,
   input  logic                           exe_branch_taken,
   input  logic [REGFILE_ADDRESS_LEN-1:0] mem_dest,
   input  logic                           mem_wb_en,
   input  logic                           mem_req_read,
   input  logic                           mem_req_write,
   input  logic                           sram_ready,
   output logic                           sram_req,
   output logic                           freeze,
   output logic                           hazard,
   output logic                           flush,
   output logic                           mem_stall,
   output logic                           timeout_err,
   output logic [CNT_LEN-1:0]             stall_count
);

   localparam int WCW = (SRAM_TIMEOUT > 1) ? $clog2(SRAM_TIMEOUT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(SRAM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [WCW-1:0]       r_wait_cnt;
   logic                 r_timeout_err;
   logic [CNT_LEN-1:0]   r_stall_count;

   logic w_req;
   logic w_m1;
   logic w_m2;
   logic w_n1;
   logic w_n2;
   logic w_raw;
   logic w_access;
   logic w_mem_stall;
   logic w_hazard;
   logic w_flush;
   logic w_freeze;

   assign w_req = mem_req_read | mem_req_write;

   // Operand matches against the producers still in flight in EXE and MEM.
   assign w_m1 = id_use_src1 & exe_wb_en & (id_src1 == exe_dest);
   assign w_m2 = id_use_src2 & exe_wb_en & (id_src2 == exe_dest);
   assign w_n1 = id_use_src1 & mem_wb_en & (id_src1 == mem_dest);
   assign w_n2 = id_use_src2 & mem_wb_en & (id_src2 == mem_dest);

`ifdef FORWARDING_EN
   // Forwarded values cover everything except a load result not yet read from memory.
   logic w_unused_fwd;
   assign w_unused_fwd = w_n1 ^ w_n2;
   assign w_raw = exe_mem_read & (w_m1 | w_m2);
`else
   // Without forwarding, the load flag carries no extra information.
   logic w_unused_fwd;
   assign w_unused_fwd = exe_mem_read;
   assign w_raw = w_m1 | w_m2 | w_n1 | w_n2;
`endif

   // The stall starts in the same cycle as the request, so the request cycle itself is included.
   assign w_access    = ((r_state == ST_IDLE) & w_req) | (r_state == ST_WAIT);
   assign w_mem_stall = rst & w_access;
   // A memory stall freezes everything. A branch held back by a stall is retried once the stall clears.
   assign w_flush     = rst & exe_branch_taken & ~w_mem_stall;
   assign w_hazard    = rst & w_raw & ~exe_branch_taken & ~w_mem_stall;
   assign w_freeze    = w_hazard | w_mem_stall;

   assign sram_req    = w_mem_stall;
   assign mem_stall   = w_mem_stall;
   assign hazard      = w_hazard;
   assign flush       = w_flush;
   assign freeze      = w_freeze;
   assign timeout_err = r_timeout_err;
   assign stall_count = r_stall_count;

   // SRAM handshake: IDLE -> WAIT on request.
   // WAIT -> DONE on ready, or after SRAM_TIMEOUT cycles. DONE lasts one cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_wait_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_state    <= ST_WAIT;
                  r_wait_cnt <= '0;
               end
            end
            ST_WAIT: begin
               if (sram_ready) begin
                  r_state <= ST_DONE;
               end else if (r_wait_cnt == WAIT_LAST) begin
                  r_state       <= ST_DONE;
                  r_timeout_err <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               // The same instruction is still in MEM, so its request must not restart an access.
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Count frozen cycles, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stall_count <= '0;
      end else if (w_freeze && (r_stall_count != {CNT_LEN{1'b1}})) begin
         r_stall_count <= r_stall_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Randomized and directed stimulus for pipeline_hazard_ctrl.
//   Outputs are checked every cycle against a transaction-level model.
//   Directed steps also carry hand-computed literal expectations.
//   The bench honours FORWARDING_EN the same way the design does.
module tb_pipeline_hazard_ctrl;

   localparam int AW  = 4;
   localparam int TO  = 15;
   localparam int CNT = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   id_src1, id_src2, exe_dest, mem_dest;
   logic            id_use_src1, id_use_src2;
   logic            exe_wb_en, exe_mem_read, exe_branch_taken;
   logic            mem_wb_en, mem_req_read, mem_req_write, sram_ready;
   logic            sram_req, freeze, hazard, flush, mem_stall, timeout_err;
   logic [CNT-1:0]  stall_count;

   int total = 0;
   int bad   = 0;

   // Model state:
   //   m_acc  - an access is in progress.
   //   m_wait - cycles already waited.
   //   m_cool - the post-access cycle.
   int m_acc, m_wait, m_cool, m_terr, m_cnt, m_xfers;
   // Expected combinational outputs for the current cycle.
   int e_stall, e_haz, e_flush, e_freeze;

   pipeline_hazard_ctrl #(
      .REGFILE_ADDRESS_LEN(AW),
      .SRAM_TIMEOUT(TO),
      .CNT_LEN(CNT)
   ) dut (
      .clk(clk), .rst(rst),
      .id_src1(id_src1), .id_src2(id_src2),
      .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
      .exe_branch_taken(exe_branch_taken),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .mem_req_read(mem_req_read), .mem_req_write(mem_req_write),
      .sram_ready(sram_ready), .sram_req(sram_req),
      .freeze(freeze), .hazard(hazard), .flush(flush), .mem_stall(mem_stall),
      .timeout_err(timeout_err), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected outputs derived directly from the rules, given the model's access status.
   task automatic model_outputs();
      int raw;
      int busy;
      logic [AW-1:0] src [2];
      logic          use_s [2];
      raw = 0;
      src[0] = id_src1;
      src[1] = id_src2;
      use_s[0] = id_use_src1;
      use_s[1] = id_use_src2;
      for (int s = 0; s < 2; s++) begin
         if (use_s[s] && exe_wb_en && src[s] == exe_dest) begin
`ifdef FORWARDING_EN
            if (exe_mem_read) raw = 1;
`else
            raw = 1;
`endif
         end
`ifndef FORWARDING_EN
         if (use_s[s] && mem_wb_en && src[s] == mem_dest) raw = 1;
`endif
      end
      busy = (m_acc != 0) || (m_cool == 0 && (mem_req_read || mem_req_write));
      if (!rst) begin
         e_stall = 0;
         e_haz = 0;
         e_flush = 0;
      end else begin
         e_stall = busy ? 1 : 0;
         e_flush = (exe_branch_taken && !e_stall) ? 1 : 0;
         e_haz   = (raw != 0 && !exe_branch_taken && !e_stall) ? 1 : 0;
      end
      e_freeze = (e_haz != 0 || e_stall != 0) ? 1 : 0;
   endtask

   // Advance the model across one rising edge, using the inputs held through it.
   task automatic model_step();
      if (!rst) begin
         m_acc = 0;
         m_wait = 0;
         m_cool = 0;
         m_terr = 0;
         m_cnt = 0;
         return;
      end
      if (e_freeze != 0 && m_cnt < (1 << CNT) - 1) m_cnt++;
      if (m_cool != 0) begin
         m_cool = 0;
      end else if (m_acc != 0) begin
         if (sram_ready) begin
            m_acc = 0;
            m_cool = 1;
            m_xfers++;
            $display("xfer %0d: ready after %0d wait cycles", m_xfers, m_wait + 1);
         end else if (m_wait + 1 == TO) begin
            m_acc = 0;
            m_cool = 1;
            m_terr = 1;
            m_xfers++;
            $display("xfer %0d: timed out after %0d wait cycles", m_xfers, TO);
         end else begin
            m_wait++;
         end
      end else if (mem_req_read || mem_req_write) begin
         m_acc = 1;
         m_wait = 0;
      end
   endtask

   // Sample at the falling edge and compare every output with the model.
   task automatic settle();
      @(negedge clk);
      model_outputs();
      chk("sram_req", sram_req, e_stall);
      chk("mem_stall", mem_stall, e_stall);
      chk("hazard", hazard, e_haz);
      chk("flush", flush, e_flush);
      chk("freeze", freeze, e_freeze);
      chk("timeout_err", timeout_err, m_terr);
      chk("stall_count", stall_count, m_cnt);
   endtask

   task automatic advance();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      id_src1 = 0; id_src2 = 0; id_use_src1 = 0; id_use_src2 = 0;
      exe_dest = 0; exe_wb_en = 0; exe_mem_read = 0; exe_branch_taken = 0;
      mem_dest = 0; mem_wb_en = 0; mem_req_read = 0; mem_req_write = 0; sram_ready = 0;
   endtask

   initial begin
      int n;
      m_acc = 0; m_wait = 0; m_cool = 0; m_terr = 0; m_cnt = 0; m_xfers = 0;
      idle_inputs();
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Reset: a request is masked while reset is held.
      mem_req_read = 1;
      settle();
      chk("rst_sram_req", sram_req, 0);
      chk("rst_count", stall_count, 0);
      advance();
      advance();
      mem_req_read = 0;
      rst = 1'b1;
      settle();
      chk("post_rst_stall", mem_stall, 0);
      chk("post_rst_terr", timeout_err, 0);
      advance();

      // Step 1: a RAW hazard against EXE.
      id_src1 = 3; id_use_src1 = 1; exe_dest = 3; exe_wb_en = 1;
      settle();
      chk("t1_hazard", hazard, 1);
      chk("t1_freeze", freeze, 1);
      advance();
      exe_wb_en = 0;
      settle();
      chk("t1_nowb_hazard", hazard, 0);
      advance();

      // Step 2: a branch beats the hazard.
      exe_wb_en = 1; exe_branch_taken = 1;
      settle();
      chk("t2_flush", flush, 1);
      chk("t2_hazard", hazard, 0);
      chk("t2_freeze", freeze, 0);
      advance();
      idle_inputs();

      // Step 3: a load whose ready arrives on the third wait cycle.
      n = 0;
      mem_req_read = 1;
      for (int c = 0; c < 5; c++) begin
         sram_ready = (c == 3);
         if (c == 4) mem_req_read = 0;
         settle();
         if (sram_req === 1'b1) n++;
         chk("t3_req_cycle", sram_req, (c < 4) ? 1 : 0);
         advance();
      end
      chk("t3_stall_len", n, 4);
      idle_inputs();

      // Step 4: a store that never gets ready and is forced to complete.
      n = 0;
      mem_req_write = 1;
      for (int c = 0; c < 17; c++) begin
         if (c == 16) mem_req_write = 0;
         settle();
         if (sram_req === 1'b1) n++;
         advance();
      end
      chk("t4_stall_len", n, 1 + TO);
      settle();
      chk("t4_terr", timeout_err, 1);
      advance();
      advance();
      settle();
      chk("t4_terr_sticky", timeout_err, 1);
      advance();

`ifdef FORWARDING_EN
      // Step 5: only load-use against EXE stalls.
      idle_inputs();
      id_src1 = 5; id_use_src1 = 1; mem_dest = 5; mem_wb_en = 1;
      settle();
      chk("t5_mem_fwd", hazard, 0);
      advance();
      idle_inputs();
      id_src2 = 6; id_use_src2 = 1; exe_dest = 6; exe_wb_en = 1; exe_mem_read = 1;
      settle();
      chk("t5_load_use", hazard, 1);
      advance();
`endif

      // Step 6: the counter saturates, then reset clears everything mid-access.
      idle_inputs();
      id_src1 = 2; id_use_src1 = 1; exe_dest = 2; exe_wb_en = 1; exe_mem_read = 1;
      for (int c = 0; c < 20; c++) begin
         settle();
         advance();
      end
      settle();
      chk("t6_saturate", stall_count, 15);
      advance();
      idle_inputs();
      mem_req_read = 1;
      settle();
      advance();
      settle();
      advance();
      rst = 1'b0;
      settle();
      chk("t6_rst_req", sram_req, 0);
      advance();
      rst = 1'b1;
      mem_req_read = 0;
      settle();
      chk("t6_rst_count", stall_count, 0);
      chk("t6_rst_terr", timeout_err, 0);
      advance();

      // Random phase.
      for (int c = 0; c < 3000; c++) begin
         rst              = ($urandom_range(0, 63) != 0);
         id_src1          = AW'($urandom_range(0, 3));
         id_src2          = AW'($urandom_range(0, 3));
         exe_dest         = AW'($urandom_range(0, 3));
         mem_dest         = AW'($urandom_range(0, 3));
         id_use_src1      = $urandom_range(0, 1) != 0;
         id_use_src2      = $urandom_range(0, 1) != 0;
         exe_wb_en        = $urandom_range(0, 1) != 0;
         exe_mem_read     = $urandom_range(0, 1) != 0;
         exe_branch_taken = ($urandom_range(0, 5) == 0);
         mem_wb_en        = $urandom_range(0, 1) != 0;
         mem_req_read     = ($urandom_range(0, 3) == 0);
         mem_req_write    = ($urandom_range(0, 4) == 0);
         sram_ready       = ($urandom_range(0, 11) == 0);
         settle();
         advance();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
